// File: rtl/latch_capture_arbiter.sv
// Two-requester round-robin arbiter that passes the winner's data through a
// capture latch. The latch is held transparent for EN_CYCLES cycles. The
// bit-reversed latched value is then presented on o_a. A one-cycle
// o_vld/o_gnt pulse marks each completed transfer.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; the only state that samples i_req and performs a grant
// OPEN  | capture latch transparent (o_en=1) for EN_CYCLES cycles
// CAPT  | latch closed; o_a loads the bit-reversed latch value on exit
// DONE  | o_vld/o_gnt pulse registered on exit, back to IDLE
//
// The o_vld/o_gnt pulse is registered at the DONE exit edge. It is therefore
// visible in the first IDLE cycle after DONE, EN_CYCLES+2 edges after the
// grant edge. That same IDLE cycle can already sample the next request, so
// back-to-back transfers complete every EN_CYCLES+3 cycles.
module latch_capture_arbiter #(
  parameter int unsigned EN_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic [3:0] i_a0,
  input  logic [3:0] i_a1,
  output logic       o_en,
  output logic [1:0] o_gnt,
  output logic [3:0] o_a,
  output logic       o_vld,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] EN_LOAD = 4'(EN_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] hold;
  logic [3:0] latch_q;
  logic       last;     // requester served most recently
  logic       sel;      // requester owning the current transfer
  logic       win;

  function automatic logic [3:0] bit_rev(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    win = 1'b0;
    case (i_req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end

  // Sequencer, enable timer, holding/latch registers and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      hold    <= 4'd0;
      latch_q <= 4'd0;
      last    <= 1'b1;      // requester 0 takes the first tie
      sel     <= 1'b0;
      o_en    <= 1'b0;
      o_gnt   <= 2'b00;
      o_a     <= 4'd0;
      o_vld   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_vld <= 1'b0;
      o_gnt <= 2'b00;
      case (state)
        IDLE: begin
          if (|i_req) begin
            sel    <= win;
            last   <= win;
            hold   <= win ? i_a1 : i_a0;
            cnt    <= EN_LOAD;
            o_en   <= 1'b1;
            o_busy <= 1'b1;
            state  <= OPEN;
          end
        end
        OPEN: begin
          // Transparent: the latch tracks the holding register only while o_en=1
          latch_q <= hold;
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            o_en  <= 1'b0;
            state <= CAPT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CAPT: begin
          o_a   <= bit_rev(latch_q);
          state <= DONE;
        end
        DONE: begin
          o_vld  <= 1'b1;
          o_gnt  <= sel ? 2'b10 : 2'b01;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_en   <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_capture_arbiter.sv
// Bench for latch_capture_arbiter. Three instances (EN_CYCLES = 1, 2, 15)
// share one stimulus stream. Each instance is compared every cycle against a
// transaction-level timeline model. Directed scenarios add fixed expected values.
module tb_latch_capture_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] a0 = 4'd0;
  logic [3:0] a1 = 4'd0;

  logic [2:0] en_v, vld_v, busy_v;
  logic [1:0] gnt_v [3];
  logic [3:0] a_v   [3];

  latch_capture_arbiter #(.EN_CYCLES(1)) u_n1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_a0(a0), .i_a1(a1),
    .o_en(en_v[0]), .o_gnt(gnt_v[0]), .o_a(a_v[0]), .o_vld(vld_v[0]), .o_busy(busy_v[0]));
  latch_capture_arbiter #(.EN_CYCLES(2)) u_n2 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_a0(a0), .i_a1(a1),
    .o_en(en_v[1]), .o_gnt(gnt_v[1]), .o_a(a_v[1]), .o_vld(vld_v[1]), .o_busy(busy_v[1]));
  latch_capture_arbiter #(.EN_CYCLES(15)) u_n15 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_a0(a0), .i_a1(a1),
    .o_en(en_v[2]), .o_gnt(gnt_v[2]), .o_a(a_v[2]), .o_vld(vld_v[2]), .o_busy(busy_v[2]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, want);
    end
  endtask

  // Timeline model: each transfer is described by the edge it was granted on
  int         e = 0;
  int         ncyc    [3] = '{1, 2, 15};
  int         en_from [3];
  int         oa_at   [3];
  int         vld_at  [3];
  int         free_at [3];
  logic       last_srv[3];
  logic       win_q   [3];
  logic [3:0] exp_a   [3];
  logic [3:0] pend_a  [3];

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      en_from[j]  = -100;
      oa_at[j]    = -100;
      vld_at[j]   = -100;
      free_at[j]  = 0;
      last_srv[j] = 1'b1;
      win_q[j]    = 1'b0;
      exp_a[j]    = 4'd0;
      pend_a[j]   = 4'd0;
    end
  endtask

  task automatic model_edge();
    for (int j = 0; j < 3; j++) begin
      logic w;
      if (e >= free_at[j] && req != 2'b00) begin
        if (req == 2'b01)      w = 1'b0;
        else if (req == 2'b10) w = 1'b1;
        else                   w = !last_srv[j];
        last_srv[j] = w;
        win_q[j]    = w;
        pend_a[j]   = rev4(w ? a1 : a0);
        en_from[j]  = e;
        oa_at[j]    = e + ncyc[j] + 1;
        vld_at[j]   = e + ncyc[j] + 2;
        free_at[j]  = e + ncyc[j] + 3;
      end
      if (e == oa_at[j]) exp_a[j] = pend_a[j];
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < 3; j++) begin
      logic       en_e, busy_e, vld_e;
      logic [1:0] gnt_e;
      en_e   = (e >= en_from[j]) && (e < en_from[j] + ncyc[j]);
      busy_e = (e >= en_from[j]) && (e <= en_from[j] + ncyc[j] + 1);
      vld_e  = (e == vld_at[j]);
      gnt_e  = vld_e ? (win_q[j] ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("n%0d_en@%0d", ncyc[j], e),   32'(en_v[j]),   32'(en_e));
      check($sformatf("n%0d_busy@%0d", ncyc[j], e), 32'(busy_v[j]), 32'(busy_e));
      check($sformatf("n%0d_vld@%0d", ncyc[j], e),  32'(vld_v[j]),  32'(vld_e));
      check($sformatf("n%0d_gnt@%0d", ncyc[j], e),  32'(gnt_v[j]),  32'(gnt_e));
      check($sformatf("n%0d_a@%0d", ncyc[j], e),    32'(a_v[j]),    32'(exp_a[j]));
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1,
                      input logic rs);
    @(negedge clk);
    req = r; a0 = d0; a1 = d1; rst = rs;
    if (rs) begin
      model_reset();
      #1 check_all();
    end
    @(posedge clk);
    e++;
    if (rs) model_reset();
    else    model_edge();
    #1 check_all();
  endtask

  initial begin
    int         n_vld, last_vld;
    int         first_vld[3];
    int         en_cnt[3];
    logic [1:0] gnt_seq[3];
    logic [3:0] a_seq[3];
    logic [1:0] r;
    logic       rs;

    model_reset();

    // Reset values and a first simple transfer from requester 0
    step(2'b00, 4'd0, 4'd0, 1'b1);
    step(2'b00, 4'd0, 4'd0, 1'b1);
    step(2'b01, 4'b0001, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(2'b00, 4'b0001, 4'd0, 1'b0);
      if (i == 1) check("r029_en1", 32'(en_v[1]), 32'd1);
      if (i == 2) check("r029_en2", 32'(en_v[1]), 32'd0);
    end
    check("r029_vld", 32'(vld_v[1]), 32'd1);
    check("r029_gnt", 32'(gnt_v[1]), 32'b01);
    check("r029_a",   32'(a_v[1]),   32'b1000);

    // Both requesting continuously: grants alternate, one result per 5 cycles
    step(2'b00, 4'd0, 4'd0, 1'b1);
    gnt_seq = '{2'b01, 2'b10, 2'b01};
    a_seq   = '{4'b1100, 4'b0110, 4'b1100};
    n_vld = 0; last_vld = 0;
    for (int i = 1; i <= 15; i++) begin
      step(2'b11, 4'b0011, 4'b0110, 1'b0);
      if (vld_v[1]) begin
        if (n_vld < 3) begin
          check("r030_gnt", 32'(gnt_v[1]), 32'(gnt_seq[n_vld]));
          check("r030_a",   32'(a_v[1]),   32'(a_seq[n_vld]));
        end
        if (n_vld > 0) check("r030_gap", 32'(i - last_vld), 32'd5);
        last_vld = i;
        n_vld++;
      end
    end
    check("r030_count", 32'(n_vld), 32'd3);

    // Requester data changing after the grant must not reach the result
    step(2'b00, 4'd0, 4'd0, 1'b1);
    step(2'b10, 4'd0, 4'b1010, 1'b0);
    for (int i = 1; i <= 4; i++) step(2'b00, 4'd0, 4'b1111, 1'b0);
    check("r031_vld", 32'(vld_v[1]), 32'd1);
    check("r031_gnt", 32'(gnt_v[1]), 32'b10);
    check("r031_a",   32'(a_v[1]),   32'b0101);

    // Reset in OPEN aborts; afterwards requester 0 wins a tie again
    step(2'b00, 4'd0, 4'd0, 1'b1);
    step(2'b01, 4'b0110, 4'd0, 1'b0);
    step(2'b00, 4'd0, 4'd0, 1'b0);
    step(2'b00, 4'd0, 4'd0, 1'b1);
    check("r032_busy", 32'(busy_v[1]), 32'd0);
    check("r032_a",    32'(a_v[1]),    32'd0);
    step(2'b11, 4'b0101, 4'b1001, 1'b0);
    n_vld = 0;
    for (int i = 1; i <= 4; i++) begin
      step(2'b00, 4'd0, 4'd0, 1'b0);
      if (vld_v[1]) n_vld++;
    end
    check("r032_vld", 32'(vld_v[1]), 32'd1);
    check("r032_gnt", 32'(gnt_v[1]), 32'b01);
    check("r032_a",   32'(a_v[1]),   32'b1010);
    check("r032_npulse", 32'(n_vld), 32'd1);

    // Enable width and latency at the parameter extremes
    step(2'b00, 4'd0, 4'd0, 1'b1);
    step(2'b01, 4'b1011, 4'd0, 1'b0);
    first_vld = '{-1, -1, -1};
    en_cnt    = '{0, 0, 0};
    for (int i = 1; i <= 20; i++) begin
      step(2'b00, 4'd0, 4'd0, 1'b0);
      for (int j = 0; j < 3; j++) begin
        if (en_v[j]) en_cnt[j]++;
        if (vld_v[j] && first_vld[j] < 0) first_vld[j] = i;
      end
    end
    // en_cnt counts cycles after the grant edge, so the grant-edge cycle is added
    check("r033_en_n1",   32'(en_cnt[0] + 1), 32'd1);
    check("r033_en_n15",  32'(en_cnt[2] + 1), 32'd15);
    check("r033_vld_n1",  32'(first_vld[0]), 32'd3);
    check("r033_vld_n15", 32'(first_vld[2]), 32'd17);
    check("r033_a_n15",   32'(a_v[2]), 32'b1101);

    // Request from requester 0 while busy for requester 1 waits for IDLE
    step(2'b00, 4'd0, 4'd0, 1'b1);
    step(2'b10, 4'd0, 4'b0111, 1'b0);
    n_vld = 0;
    for (int i = 1; i <= 9; i++) begin
      step(2'b01, 4'b0010, 4'd0, 1'b0);
      if (i == 4) begin
        check("r034_gnt1", 32'(gnt_v[1]), 32'b10);
        check("r034_a1",   32'(a_v[1]),   32'b1110);
      end
      if (i == 9) begin
        check("r034_gnt0", 32'(gnt_v[1]), 32'b01);
        check("r034_a0",   32'(a_v[1]),   32'b0100);
      end
    end

    // Randomized traffic with occasional resets, checked against the model
    r = 2'b00;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) r = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 199) == 0);
      step(r, 4'($urandom), 4'($urandom), rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
